mem_port_arbiter: RTL

- Shares one single-port, fixed-latency memory port between two requesters: instruction fetch (read-only) and load/store unit (read/write, byte enables).
- Sits between the core's fetch/LSU stages and the RAM data port.
- Exactly one transaction is outstanding at a time. Responses are registered and routed back to the requester that won arbitration.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between instruction fetch
//   (read-only) and the load/store unit (read/write with byte enables).
//   One transaction outstanding at a time; the response is registered and
//   routed back to whichever requester won arbitration.
//
// Parameters
//   LATENCY   cycles from the mem_req cycle until mem_rdata is valid (1..15)
//
// Configuration
//   MEM_PORT_ARB_RR_EN  when defined, ties alternate between requesters
//                       (first tie after reset goes to LSU); otherwise the
//                       LSU has fixed priority over fetch.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   if_req/if_addr -> if_gnt            fetch request / same-cycle accept
//   if_rvalid/if_rdata                  fetch response (1-cycle pulse)
//   lsu_req/we/addr/wdata/be -> lsu_gnt LSU request / same-cycle accept
//   lsu_rvalid/lsu_rdata                LSU response or write-ack (rdata 0)
//   mem_req/we/addr/wdata/be            memory access strobe and fields
//   mem_rdata                           read data, LATENCY cycles after req
module mem_port_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_be,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: LATENCY must be in 1..15");
  end

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       owner;     // 0 = fetch, 1 = LSU
  logic       owner_we;  // outstanding access is an LSU write: respond with 0
  logic       pick_lsu;
  logic       issue;

  // Grants are gated by rst_n so nothing leaks out while reset is held.
  assign issue   = rst_n && (state == IDLE) && (if_req || lsu_req);
  assign lsu_gnt = issue &&  pick_lsu;
  assign if_gnt  = issue && !pick_lsu;

`ifdef MEM_PORT_ARB_RR_EN
  // last_lsu records who won the previous grant; a tie goes to the other one.
  logic last_lsu;
  assign pick_lsu = (lsu_req && if_req) ? !last_lsu : lsu_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_lsu <= 1'b0;
    else if (issue) last_lsu <= pick_lsu;
  end
`else
  assign pick_lsu = lsu_req;
`endif

  // Memory-side fields come from the winner; all zero when idle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (issue) begin
      mem_req = 1'b1;
      if (pick_lsu) begin
        mem_we    = lsu_we;
        mem_addr  = lsu_addr;
        mem_wdata = lsu_wdata;
        mem_be    = lsu_be;
      end else begin
        mem_addr  = if_addr;
        mem_be    = 4'hF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      owner_we   <= 1'b0;
      if_rvalid  <= 1'b0;
      lsu_rvalid <= 1'b0;
      if_rdata   <= '0;
      lsu_rdata  <= '0;
    end else begin
      if_rvalid  <= 1'b0;
      lsu_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            owner    <= pick_lsu;
            owner_we <= pick_lsu && lsu_we;
            cnt      <= 4'(LATENCY);
            state    <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // cnt reaches 1 in the cycle mem_rdata is valid.
          if (cnt == 4'd1) begin
            state <= IDLE;
            if (owner) begin
              lsu_rvalid <= 1'b1;
              lsu_rdata  <= owner_we ? 32'h0 : mem_rdata;
            end else begin
              if_rvalid  <= 1'b1;
              if_rdata   <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
